// File: rtl/sm3_pkg.sv
// Shared SM3 message-path definitions: word geometry, packer state, mask helper.
// Word width follows SM3_INPT_DW_64 from the sm3_cfg.v macro set.
package sm3_pkg;

`ifdef SM3_INPT_DW_64
    localparam int INPT_DW = 64;
`else
    localparam int INPT_DW = 32;
`endif
    localparam int WORD_BYTES = INPT_DW / 8;
    localparam int ACC_W = $clog2(WORD_BYTES);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FILL  = 1'b1
    } pk_state_t;

    // Ones in the top (cnt+1) lanes, first byte in the MSB lane.
    function automatic logic [WORD_BYTES-1:0] vld_mask(
        input logic [ACC_W-1:0] cnt
    );
        logic [WORD_BYTES-1:0] m;
        m = '0;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (i <= int'(cnt)) m[WORD_BYTES-1-i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/sm3_byte_packer.sv
// Packs a byte stream into left-aligned SM3 input words with a
// valid-byte mask, last flag, running byte count and done pulse.
module sm3_byte_packer
    import sm3_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            byte_in_d,
    input  logic                  byte_in_vld,
    input  logic                  byte_in_lst,
    output logic                  byte_in_rdy,
    output logic [INPT_DW-1:0]    msg_inpt_d,
    output logic [WORD_BYTES-1:0] msg_inpt_vld_byte,
    output logic                  msg_inpt_vld,
    output logic                  msg_inpt_lst,
    input  logic                  msg_inpt_rdy,
    output logic [60:0]           msg_byte_cnt,
    output logic                  msg_done
);

    pk_state_t             r_state;
    logic [ACC_W-1:0]      r_acc_cnt;
    logic [INPT_DW-1:0]    r_acc;
    logic [INPT_DW-1:0]    r_d;
    logic [WORD_BYTES-1:0] r_mask;
    logic                  r_vld;
    logic                  r_lst;
    logic [60:0]           r_byte_cnt;

    logic                  w_byte_acc;
    logic                  w_word_xfer;
    logic                  w_complete;
    logic                  w_last_lane;
    logic [ACC_W+2:0]      w_shift;
    logic [INPT_DW-1:0]    w_lane;
    logic [INPT_DW-1:0]    w_base;
    logic [INPT_DW-1:0]    w_merged;

    // Ready depends combinationally on the downstream ready.
    assign byte_in_rdy = !r_vld || msg_inpt_rdy;
    assign w_byte_acc  = byte_in_vld && byte_in_rdy;
    assign w_word_xfer = r_vld && msg_inpt_rdy;
    assign w_last_lane = (r_acc_cnt == ACC_W'(WORD_BYTES - 1));
    assign w_complete  = w_byte_acc && (w_last_lane || byte_in_lst);

    assign w_shift  = {r_acc_cnt, 3'b000};
    assign w_lane   = {byte_in_d, {(INPT_DW-8){1'b0}}} >> w_shift;
    assign w_base   = (r_state == ST_FILL) ? r_acc : '0;
    assign w_merged = w_base | w_lane;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_EMPTY;
            r_acc_cnt <= '0;
            r_acc     <= '0;
        end else if (w_byte_acc) begin
            if (w_complete) begin
                r_state   <= ST_EMPTY;
                r_acc_cnt <= '0;
                r_acc     <= '0;
            end else begin
                r_state   <= ST_FILL;
                r_acc_cnt <= r_acc_cnt + ACC_W'(1);
                r_acc     <= w_merged;
            end
        end
    end

    // A completing byte may reload the register in the same cycle it drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d    <= '0;
            r_mask <= '0;
            r_vld  <= 1'b0;
            r_lst  <= 1'b0;
        end else if (w_complete) begin
            r_d    <= w_merged;
            r_mask <= vld_mask(r_acc_cnt);
            r_vld  <= 1'b1;
            r_lst  <= byte_in_lst;
        end else if (w_word_xfer) begin
            r_vld  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte_cnt <= '0;
        end else if (msg_done) begin
            r_byte_cnt <= w_byte_acc ? 61'd1 : 61'd0;
        end else if (w_byte_acc) begin
            r_byte_cnt <= r_byte_cnt + 61'd1;
        end
    end

    assign msg_inpt_d        = r_d;
    assign msg_inpt_vld_byte = r_mask;
    assign msg_inpt_vld      = r_vld;
    assign msg_inpt_lst      = r_lst;
    assign msg_byte_cnt      = r_byte_cnt;
    assign msg_done          = w_word_xfer && r_lst;

endmodule

// File: tb/tb_sm3_byte_packer.sv
// Directed and random bench for sm3_byte_packer (32-bit word build).
// Expected words are queued at stimulus time and popped on each transfer.
module tb_sm3_byte_packer;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  m;
        logic        lst;
        logic [60:0] cnt;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [7:0]  byte_in_d;
    logic        byte_in_vld;
    logic        byte_in_lst;
    logic        byte_in_rdy;
    logic [31:0] msg_inpt_d;
    logic [3:0]  msg_inpt_vld_byte;
    logic        msg_inpt_vld;
    logic        msg_inpt_lst;
    logic        msg_inpt_rdy;
    logic [60:0] msg_byte_cnt;
    logic        msg_done;

    int checks = 0;
    int errors = 0;
    exp_t q[$];

    int mode = 0;
    int stall_left = 0;
    bit use_model = 0;
    logic [31:0] mdl_acc;
    int mdl_cnt;
    int mdl_len;

    sm3_byte_packer dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .byte_in_d         (byte_in_d),
        .byte_in_vld       (byte_in_vld),
        .byte_in_lst       (byte_in_lst),
        .byte_in_rdy       (byte_in_rdy),
        .msg_inpt_d        (msg_inpt_d),
        .msg_inpt_vld_byte (msg_inpt_vld_byte),
        .msg_inpt_vld      (msg_inpt_vld),
        .msg_inpt_lst      (msg_inpt_lst),
        .msg_inpt_rdy      (msg_inpt_rdy),
        .msg_byte_cnt      (msg_byte_cnt),
        .msg_done          (msg_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic [3:0] m,
                        input logic lst, input logic [60:0] cnt);
        exp_t e;
        e.d = d; e.m = m; e.lst = lst; e.cnt = cnt;
        q.push_back(e);
    endtask

    // Downstream ready policy: 0 always ready, 1 random, 2 stall on word.
    task automatic tick();
        if (mode == 1) begin
            msg_inpt_rdy = 1'($urandom_range(0, 1));
        end else if (mode == 2 && stall_left > 0 && msg_inpt_vld) begin
            msg_inpt_rdy = 1'b0;
            stall_left--;
        end else begin
            msg_inpt_rdy = 1'b1;
        end
    endtask

    task automatic model_byte(input logic [7:0] b, input logic lst);
        logic [3:0] m;
        mdl_acc[31-8*mdl_cnt -: 8] = b;
        mdl_len++;
        if (mdl_cnt == 3 || lst) begin
            m = '0;
            for (int k = 0; k <= mdl_cnt; k++) m[3-k] = 1'b1;
            push(mdl_acc, m, lst, 61'(mdl_len));
            mdl_acc = '0;
            mdl_cnt = 0;
            if (lst) mdl_len = 0;
        end else begin
            mdl_cnt++;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic lst);
        int n;
        bit acc;
        n = 0;
        acc = 0;
        byte_in_d   = b;
        byte_in_vld = 1'b1;
        byte_in_lst = lst;
        while (!acc && n < 64) begin
            @(negedge clk);
            acc = byte_in_rdy;
            @(posedge clk);
            #1;
            tick();
            n++;
        end
        byte_in_vld = 1'b0;
        byte_in_lst = 1'b0;
        if (!acc) chk("byte_accept_timeout", 64'(acc), 64'd1);
        else if (use_model) model_byte(b, lst);
    endtask

    task automatic drain();
        int n;
        n = 0;
        mode = 0;
        while (q.size() > 0 && n < 300) begin
            @(posedge clk);
            #1;
            tick();
            n++;
        end
        repeat (2) begin
            @(posedge clk);
            #1;
            tick();
        end
        chk("drain_queue", 64'(q.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && msg_inpt_vld && msg_inpt_rdy) begin
            if (q.size() == 0) begin
                chk("extra_word", 64'(msg_inpt_d), 64'hdead_beef_0000);
            end else begin
                e = q.pop_front();
                chk("word_d", 64'(msg_inpt_d), 64'(e.d));
                chk("word_mask", 64'(msg_inpt_vld_byte), 64'(e.m));
                chk("word_lst", 64'(msg_inpt_lst), 64'(e.lst));
                chk("word_done", 64'(msg_done), 64'(e.lst));
                if (e.lst) chk("msg_len", 64'(msg_byte_cnt), 64'(e.cnt));
            end
        end else if (rst_n) begin
            chk("done_idle", 64'(msg_done), 64'd0);
        end
        if (rst_n && msg_inpt_vld && !msg_inpt_rdy) begin
            chk("stall_rdy", 64'(byte_in_rdy), 64'd0);
            if (q.size() > 0) begin
                chk("stall_d", 64'(msg_inpt_d), 64'(q[0].d));
                chk("stall_mask", 64'(msg_inpt_vld_byte), 64'(q[0].m));
            end
        end
    end

    initial begin
        int len;
        rst_n        = 1'b0;
        byte_in_d    = '0;
        byte_in_vld  = 1'b0;
        byte_in_lst  = 1'b0;
        msg_inpt_rdy = 1'b1;
        mdl_acc = '0;
        mdl_cnt = 0;
        mdl_len = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_vld", 64'(msg_inpt_vld), 64'd0);
        chk("rst_lst", 64'(msg_inpt_lst), 64'd0);
        chk("rst_d", 64'(msg_inpt_d), 64'd0);
        chk("rst_mask", 64'(msg_inpt_vld_byte), 64'd0);
        chk("rst_cnt", 64'(msg_byte_cnt), 64'd0);
        chk("rst_done", 64'(msg_done), 64'd0);
        chk("rst_rdy", 64'(byte_in_rdy), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_rdy", 64'(byte_in_rdy), 64'd1);
        @(posedge clk);
        #1;

        // "abc" with lst on 'c'
        push(32'h6162_6300, 4'b1110, 1'b1, 61'd3);
        send_byte(8'h61, 1'b0);
        send_byte(8'h62, 1'b0);
        send_byte(8'h63, 1'b1);
        @(negedge clk);
        chk("latency_vld", 64'(msg_inpt_vld), 64'd1);
        chk("cnt_before_clr", 64'(msg_byte_cnt), 64'd3);
        @(posedge clk);
        #1;
        tick();
        @(negedge clk);
        chk("cnt_after_done", 64'(msg_byte_cnt), 64'd0);
        chk("vld_after_xfer", 64'(msg_inpt_vld), 64'd0);
        drain();

        // five bytes spill into a second word
        push(32'h6162_6364, 4'b1111, 1'b0, 61'd0);
        push(32'h6500_0000, 4'b1000, 1'b1, 61'd5);
        for (int i = 0; i < 5; i++) send_byte(8'(8'h61 + i), i == 4);
        drain();

        // lst without vld must do nothing
        byte_in_lst = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        byte_in_lst = 1'b0;
        @(negedge clk);
        chk("lst_no_vld", 64'(msg_inpt_vld), 64'd0);
        chk("lst_no_vld_cnt", 64'(msg_byte_cnt), 64'd0);
        drain();

        // 3-cycle downstream stall after the first word
        mode = 2;
        stall_left = 3;
        push(32'h0102_0304, 4'b1111, 1'b0, 61'd0);
        push(32'h0506_0708, 4'b1111, 1'b1, 61'd8);
        for (int i = 0; i < 8; i++) send_byte(8'(i + 1), i == 7);
        chk("stall_used", 64'(stall_left), 64'd0);
        drain();

        // back-to-back "abc" then "abcd"
        push(32'h6162_6300, 4'b1110, 1'b1, 61'd3);
        push(32'h6162_6364, 4'b1111, 1'b1, 61'd4);
        send_byte(8'h61, 1'b0);
        send_byte(8'h62, 1'b0);
        send_byte(8'h63, 1'b1);
        send_byte(8'h61, 1'b0);
        send_byte(8'h62, 1'b0);
        send_byte(8'h63, 1'b0);
        send_byte(8'h64, 1'b1);
        drain();

        // reset mid-message discards the partial word
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_vld", 64'(msg_inpt_vld), 64'd0);
        chk("midrst_cnt", 64'(msg_byte_cnt), 64'd0);
        chk("midrst_rdy", 64'(byte_in_rdy), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push(32'h6162_6300, 4'b1110, 1'b1, 61'd3);
        send_byte(8'h61, 1'b0);
        send_byte(8'h62, 1'b0);
        send_byte(8'h63, 1'b1);
        drain();

        // random lengths under random downstream ready
        use_model = 1;
        for (int m = 0; m < 5; m++) begin
            len = $urandom_range(1, 136);
            mode = 1;
            for (int i = 0; i < len; i++)
                send_byte(8'($urandom), i == len - 1);
        end
        drain();

        chk("final_queue", 64'(q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
